// File: rtl/da_dct8_stream.sv
// 8-point 1-D DCT-II engine using distributed arithmetic.
// It has valid/ready streaming on both sides, a butterfly front end and saturating outputs.
//
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   in_valid/in_ready     : sample handshake
//   in_data[DW]           : signed sample x[n], n = 0..7 in arrival order
//   out_valid/out_ready   : coefficient handshake
//   out_data[OW]          : signed coefficient Y[k]
//   out_idx[3]            : k of the current coefficient
//   out_last              : high with k = NCOEF-1
//   busy                  : high in any state other than LOAD
module da_dct8_stream #(
  parameter int DW    = 12,
  parameter int OW    = 16,
  parameter int SHIFT = 14,
  parameter int NCOEF = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic [2:0]    out_idx,
  output logic          out_last,
  output logic          busy
);

  localparam int CW = 16;
  localparam int RW = CW + 3;
  localparam int AW = DW + CW + 6;
  localparam int BW = DW + 1;

  localparam logic signed [AW-1:0] YMAX =
    {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN =
    {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [2:0] {
    LOAD, BFLY, ACC, SCALE, OUT
  } state_t;

  // cos(m*pi/16) in Q2.14 for m = 0..8
  function automatic int cos_tab(input int m);
    case (m)
      0:       return 16384;
      1:       return 16069;
      2:       return 15137;
      3:       return 13623;
      4:       return 11585;
      5:       return 9102;
      6:       return 6270;
      7:       return 3196;
      default: return 0;
    endcase
  endfunction

  function automatic int cos_q(input int m);
    int r;
    r = m % 32;
    if (r > 16) r = 32 - r;
    if (r > 8) return -cos_tab(16 - r);
    return cos_tab(r);
  endfunction

  function automatic int coef(input int k, input int n);
    if (k == 0) return 11585;
    return cos_q((2*n + 1) * k);
  endfunction

  // Partial-sum entry: address bit 3 selects n=0, bit 0 selects n=3.
  function automatic int rom_val(input int k, input int a);
    int s;
    s = 0;
    for (int n = 0; n < 4; n++)
      if (a[3-n]) s += coef(k, n);
    return s;
  endfunction

  function automatic logic [8*16*RW-1:0] rom_init();
    logic [8*16*RW-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++)
      for (int a = 0; a < 16; a++)
        v[(k*16 + a)*RW +: RW] = RW'(rom_val(k, a));
    return v;
  endfunction

  localparam logic [8*16*RW-1:0] ROM = rom_init();

  state_t r_state;
  state_t w_next;

  logic signed [DW-1:0] r_x [8];
  logic [2:0]           r_cnt;
  logic [BW-1:0]        r_s [4];
  logic [BW-1:0]        r_d [4];
  logic [4:0]           r_bit;
  logic signed [AW-1:0] r_acc [8];
  logic signed [OW-1:0] r_y [8];
  logic [2:0]           r_k;
  logic                 r_ov;
  logic [OW-1:0]        r_od;
  logic [2:0]           r_oi;
  logic                 r_ol;

  logic [3:0]           w_sa;
  logic [3:0]           w_da;
  logic signed [RW-1:0] w_part [8];
  logic signed [AW-1:0] w_sh [8];
  logic signed [OW-1:0] w_y [8];

  assign in_ready  = (r_state == LOAD);
  assign busy      = (r_state != LOAD);
  assign out_valid = r_ov;
  assign out_data  = r_od;
  assign out_idx   = r_oi;
  assign out_last  = r_ol;

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LOAD:
        if (in_valid && r_cnt == 3'd7)
          w_next = BFLY;
      BFLY:  w_next = ACC;
      ACC:
        if (r_bit == '0)
          w_next = SCALE;
      SCALE: w_next = OUT;
      OUT:
        if (r_ov && r_ol && out_ready)
          w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  // Shift registers present the current bit at the MSB, so
  // processing is MSB (sign) first: acc = -P, then 2*acc + P.
  assign w_sa = {r_s[0][BW-1], r_s[1][BW-1],
                 r_s[2][BW-1], r_s[3][BW-1]};
  assign w_da = {r_d[0][BW-1], r_d[1][BW-1],
                 r_d[2][BW-1], r_d[3][BW-1]};

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_part[k] = ROM[(k*16 + int'((k % 2 == 0) ? w_sa : w_da))*RW +: RW];
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_sh[k] = r_acc[k] >>> SHIFT;
      if (w_sh[k] > YMAX)      w_y[k] = OW'(YMAX);
      else if (w_sh[k] < YMIN) w_y[k] = OW'(YMIN);
      else                     w_y[k] = OW'(w_sh[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_bit <= '0;
      r_k   <= '0;
      r_ov  <= 1'b0;
      r_od  <= '0;
      r_oi  <= '0;
      r_ol  <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (in_valid) begin
            r_x[r_cnt] <= in_data;
            r_cnt      <= r_cnt + 3'd1;
          end
        end
        BFLY: begin
          for (int n = 0; n < 4; n++) begin
            r_s[n] <= BW'(r_x[n]) + BW'(r_x[7-n]);
            r_d[n] <= BW'(r_x[n]) - BW'(r_x[7-n]);
          end
          r_bit <= 5'(DW);
        end
        ACC: begin
          for (int k = 0; k < 8; k++) begin
            if (r_bit == 5'(DW))
              r_acc[k] <= -(AW'(w_part[k]));
            else
              r_acc[k] <= (r_acc[k] <<< 1) + AW'(w_part[k]);
          end
          for (int n = 0; n < 4; n++) begin
            r_s[n] <= r_s[n] << 1;
            r_d[n] <= r_d[n] << 1;
          end
          r_bit <= r_bit - 5'd1;
        end
        SCALE: begin
          for (int k = 0; k < 8; k++)
            r_y[k] <= w_y[k];
          r_k <= '0;
        end
        OUT: begin
          if (!r_ov || out_ready) begin
            if (r_ov && r_ol) begin
              r_ov <= 1'b0;
            end else begin
              r_ov <= 1'b1;
              r_od <= r_y[r_k];
              r_oi <= r_k;
              r_ol <= (r_k == 3'(NCOEF-1));
              r_k  <= r_k + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
